// File: rtl/btn_pkg.sv
// Shared definitions for the key-handling blocks (debouncer and
// button_event_fsm).
//   - btn_state_t  : 2-bit state encoding of the button event FSM
//   - ms_to_cycles : converts a duration in milliseconds to clock cycles
//   - cnt_width    : bit width needed for a counter that reaches max_count
//   - max_int      : larger of two integers, for sizing shared counters
package btn_pkg;

  typedef enum logic [1:0] {
    ST_ARM   = 2'd0,
    ST_IDLE  = 2'd1,
    ST_PRESS = 2'd2,
    ST_HOLD  = 2'd3
  } btn_state_t;

  function automatic int ms_to_cycles(input int clk_freq, input int ms);
    return (clk_freq / 1000) * ms;
  endfunction

  function automatic int cnt_width(input int max_count);
    int w;
    w = $clog2(max_count + 1);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_event_fsm.sv
// Turns one debounced key level into single-cycle UI events.
//
// Parameters:
//   CLK_FREQ   - clock frequency in Hz
//   LONG_MS    - hold time in ms before long_pulse fires
//   REPEAT_MS  - auto-repeat period in ms once the key is in the long hold
//   REPEAT_EN  - 1 enables repeat_pulse, 0 keeps it low
//   ACTIVE_LOW - 1 means btn_level = 0 is "pressed"
//
// Ports:
//   clk           - system clock
//   rst           - synchronous active-high reset
//   btn_level     - debounced, already-synchronous key level
//   press_pulse   - one cycle on press
//   release_pulse - one cycle on any release
//   short_pulse   - one cycle on a release before the long threshold
//   long_pulse    - one cycle when the hold reaches LONG_MS
//   repeat_pulse  - one cycle every REPEAT_MS after long_pulse while held
//   held          - high from the press_pulse cycle through the release_pulse cycle
module button_event_fsm
  import btn_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int LONG_MS    = 1000,
  parameter int REPEAT_MS  = 200,
  parameter int REPEAT_EN  = 1,
  parameter int ACTIVE_LOW = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic short_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic held
);

  localparam int LONG_CNT = ms_to_cycles(CLK_FREQ, LONG_MS);
  localparam int REP_CNT  = ms_to_cycles(CLK_FREQ, REPEAT_MS);
  localparam int CNT_W    = cnt_width(max_int(LONG_CNT, REP_CNT));

  // Terminal counts: the counter holds the number of cycles already spent
  // in the state, so the event fires when it shows N-1.
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CNT - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REP_CNT - 1);
  localparam logic             LVL_INV   = (ACTIVE_LOW != 0);
  localparam logic             RPT_ON    = (REPEAT_EN != 0);

  logic             pressed;
  btn_state_t       state,   state_nxt;
  logic [CNT_W-1:0] cnt,     cnt_nxt;
  logic             press_nxt;
  logic             release_nxt;
  logic             short_nxt;
  logic             long_nxt;
  logic             repeat_nxt;
  logic             held_nxt;

  assign pressed = btn_level ^ LVL_INV;

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    short_nxt   = 1'b0;
    long_nxt    = 1'b0;
    repeat_nxt  = 1'b0;

    case (state)
      // A key already down when reset releases must be let go first,
      // otherwise the debouncer's reset value could fake a press.
      ST_ARM: begin
        cnt_nxt = '0;
        if (!pressed) begin
          state_nxt = ST_IDLE;
        end
      end

      ST_IDLE: begin
        cnt_nxt = '0;
        if (pressed) begin
          state_nxt = ST_PRESS;
          press_nxt = 1'b1;
        end
      end

      // Release is tested first so it wins over a coincident threshold.
      ST_PRESS: begin
        if (!pressed) begin
          state_nxt   = ST_IDLE;
          release_nxt = 1'b1;
          short_nxt   = 1'b1;
          cnt_nxt     = '0;
        end else if (cnt == LONG_LAST) begin
          state_nxt = ST_HOLD;
          long_nxt  = 1'b1;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      // With repeat disabled the counter is simply parked at zero.
      ST_HOLD: begin
        if (!pressed) begin
          state_nxt   = ST_IDLE;
          release_nxt = 1'b1;
          cnt_nxt     = '0;
        end else if (RPT_ON && (cnt == REP_LAST)) begin
          repeat_nxt = 1'b1;
          cnt_nxt    = '0;
        end else if (RPT_ON) begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      default: begin
        state_nxt = ST_ARM;
        cnt_nxt   = '0;
      end
    endcase

    // held covers the whole key-down interval including the release cycle.
    held_nxt = (state_nxt == ST_PRESS) || (state_nxt == ST_HOLD) || release_nxt;
  end

  // Stage boundary: state, counter and every event output are registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_ARM;
      cnt           <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      short_pulse   <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
      held          <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      press_pulse   <= press_nxt;
      release_pulse <= release_nxt;
      short_pulse   <= short_nxt;
      long_pulse    <= long_nxt;
      repeat_pulse  <= repeat_nxt;
      held          <= held_nxt;
    end
  end

endmodule

// File: tb/tb_button_event_fsm.sv
// Bench for button_event_fsm: two instances (repeat enabled / disabled)
// share one key input; a timing model built from "cycles since press"
// predicts every output each cycle, and directed scenarios pin the model
// with literal event offsets and counts.
module tb_button_event_fsm;

  localparam int LONG = 10;
  localparam int REP  = 4;

  logic clk = 1'b0;
  logic rst;
  logic btn;

  always #5 clk = ~clk;

  logic a_press, a_rel, a_short, a_long, a_rep, a_held;
  logic b_press, b_rel, b_short, b_long, b_rep, b_held;

  button_event_fsm #(
    .CLK_FREQ(1000), .LONG_MS(LONG), .REPEAT_MS(REP), .REPEAT_EN(1), .ACTIVE_LOW(1)
  ) dut_a (
    .clk(clk), .rst(rst), .btn_level(btn),
    .press_pulse(a_press), .release_pulse(a_rel), .short_pulse(a_short),
    .long_pulse(a_long), .repeat_pulse(a_rep), .held(a_held)
  );

  button_event_fsm #(
    .CLK_FREQ(1000), .LONG_MS(LONG), .REPEAT_MS(REP), .REPEAT_EN(0), .ACTIVE_LOW(1)
  ) dut_b (
    .clk(clk), .rst(rst), .btn_level(btn),
    .press_pulse(b_press), .release_pulse(b_rel), .short_pulse(b_short),
    .long_pulse(b_long), .repeat_pulse(b_rep), .held(b_held)
  );

  // Output bundle order: {press, release, short, long, repeat, held}
  logic [5:0] dut_o [2];
  always_comb begin
    dut_o[0] = {a_press, a_rel, a_short, a_long, a_rep, a_held};
    dut_o[1] = {b_press, b_rel, b_short, b_long, b_rep, b_held};
  end

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Model: a press is tracked by the number of cycles elapsed since its
  // press_pulse; every event follows from that number and the key level.
  bit         m_arm [2];
  bit         m_act [2];
  int         m_el  [2];
  logic [5:0] exp_o [2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic pr, e_p, e_r, e_s, e_l, e_t;
      pr  = ~btn;
      e_p = 0; e_r = 0; e_s = 0; e_l = 0; e_t = 0;
      if (rst) begin
        m_arm[i] = 1;
        m_act[i] = 0;
        m_el[i]  = 0;
      end else if (m_arm[i]) begin
        if (!pr) m_arm[i] = 0;
      end else if (!m_act[i]) begin
        if (pr) begin
          m_act[i] = 1;
          m_el[i]  = 0;
          e_p      = 1;
        end
      end else begin
        m_el[i] = m_el[i] + 1;
        if (!pr) begin
          e_r      = 1;
          e_s      = (m_el[i] <= LONG);
          m_act[i] = 0;
        end else if (m_el[i] == LONG) begin
          e_l = 1;
        end else if (i == 0 && m_el[i] > LONG && ((m_el[i] - LONG) % REP) == 0) begin
          e_t = 1;
        end
      end
      exp_o[i] = {e_p, e_r, e_s, e_l, e_t, (m_act[i] | e_r)};
    end
  end

  int cyc = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        total++;
        if (dut_o[i] !== exp_o[i]) begin
          bad++;
          $display("FAIL model_cmp inst%0d cyc=%0d actual=%b required=%b", i, cyc, dut_o[i], exp_o[i]);
        end
      end
    end
  end

  // Event log for the literal checks.
  int n_press0, n_rel0, n_short0, n_long0, n_rep0;
  int n_long1, n_rep1, n_held1;
  int t_press0, t_long0, t_rel0;
  int rep_t[$];

  always @(negedge clk) begin
    cyc++;
    if (a_press) begin n_press0++; t_press0 = cyc; end
    if (a_rel)   begin n_rel0++;   t_rel0   = cyc; end
    if (a_short) n_short0++;
    if (a_long)  begin n_long0++;  t_long0  = cyc; end
    if (a_rep)   begin n_rep0++;   rep_t.push_back(cyc); end
    if (b_long)  n_long1++;
    if (b_rep)   n_rep1++;
    if (b_held)  n_held1++;
  end

  task automatic clr();
    n_press0 = 0; n_rel0 = 0; n_short0 = 0; n_long0 = 0; n_rep0 = 0;
    n_long1 = 0; n_rep1 = 0; n_held1 = 0;
    t_press0 = -1000; t_long0 = -1000; t_rel0 = -1000;
    rep_t.delete();
  endtask

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Drive the key level, then let n rising edges sample it.
  task automatic step(input logic b, input int n);
    btn = b;
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    rst = 1'b1;
    btn = 1'b0;
    clr();
    @(posedge clk);
    #2;
    chk_en = 1'b1;
    step(1'b0, 2);
    chk("reset_outputs_a", int'(dut_o[0]), 0);
    chk("reset_outputs_b", int'(dut_o[1]), 0);

    // Key held through reset: nothing until it is let go.
    rst = 1'b0;
    step(1'b0, 20);
    chk("arm_no_press", n_press0, 0);
    chk("arm_no_release", n_rel0, 0);
    step(1'b1, 3);
    clr();
    step(1'b0, 3);
    chk("arm_then_press", n_press0, 1);
    step(1'b1, 5);

    // Short press of 5 cycles.
    clr();
    step(1'b0, 5);
    step(1'b1, 5);
    chk("short_rel_offset", t_rel0 - t_press0, 5);
    chk("short_short_cnt", n_short0, 1);
    chk("short_no_long", n_long0, 0);

    // Hold 25 cycles: long at +10, repeats at +14/+18/+22.
    clr();
    step(1'b0, 25);
    step(1'b1, 5);
    chk("hold_long_offset", t_long0 - t_press0, 10);
    chk("hold_rep_count", rep_t.size(), 3);
    if (rep_t.size() == 3) begin
      chk("hold_rep0", rep_t[0] - t_press0, 14);
      chk("hold_rep1", rep_t[1] - t_press0, 18);
      chk("hold_rep2", rep_t[2] - t_press0, 22);
    end
    chk("hold_no_short", n_short0, 0);
    chk("hold_rel_cnt", n_rel0, 1);
    chk("hold_b_long", n_long1, 1);
    chk("hold_b_no_rep", n_rep1, 0);

    // Release exactly when the long threshold would fire.
    clr();
    step(1'b0, 10);
    step(1'b1, 5);
    chk("edge_no_long", n_long0, 0);
    chk("edge_short", n_short0, 1);
    chk("edge_rel_offset", t_rel0 - t_press0, 10);

    // Hold 30 cycles: repeat-disabled instance gives one long and no repeats;
    // the repeat due at +30 loses to the release on instance a.
    clr();
    step(1'b0, 30);
    step(1'b1, 5);
    chk("rd_long_once", n_long1, 1);
    chk("rd_no_repeat", n_rep1, 0);
    chk("rd_held_cycles", n_held1, 31);
    chk("a_rep_release_prio", n_rep0, 4);

    // Reset in the middle of a hold with the key still down.
    clr();
    step(1'b0, 15);
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_a", int'(dut_o[0]), 0);
    chk("midrst_out_b", int'(dut_o[1]), 0);
    clr();
    step(1'b0, 10);
    chk("midrst_no_press", n_press0, 0);
    step(1'b1, 3);
    step(1'b0, 3);
    chk("midrst_new_press", n_press0, 1);
    step(1'b1, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
